// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the RV32I hazard/forwarding controller.
//   fwd_sel_t   : execute-stage operand mux select
//   hz_state_t  : pipeline freeze FSM state
//   RESULT_LOAD : ResultSrcD encoding that marks a load
// ---------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // operand from register file (RD1E/RD2E)
      FWD_WB  = 2'b01,   // operand from writeback result (WD3)
      FWD_ALU = 2'b10    // operand from ALUResultM
   } fwd_sel_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Pipeline <-> hazard controller signal bundle.
//   master : pipeline side (drives decode/execute/memory status, reads controls)
//   slave  : hazard controller side
//   Inputs to controller : Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemOpD,
//                          PCSrcE, MemBusyM
//   Outputs              : ForwardAE, ForwardBE, StallF/D/E/M/W, FlushD/E,
//                          MemTimeout
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic [REG_AW-1:0] RdD;
   logic              RegWriteD;
   logic [1:0]        ResultSrcD;
   logic              MemOpD;
   logic              PCSrcE;
   logic              MemBusyM;

   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic              StallF;
   logic              StallD;
   logic              StallE;
   logic              StallM;
   logic              StallW;
   logic              FlushD;
   logic              FlushE;
   logic              MemTimeout;

   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemOpD, PCSrcE, MemBusyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, MemTimeout
   );

   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemOpD, PCSrcE, MemBusyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, MemTimeout
   );
endinterface

// File: rtl/hazard_stage_track.sv
// ---------------------------------------------------------------------------
// hazard_stage_track
//   One shadow pipeline-stage register. Holds while stalled, loads an all-zero
//   (invalid) entry when flushed, otherwise captures the previous stage.
//   clk, rst : clock, synchronous active-high reset (entry cleared)
//   stall_i  : hold current entry
//   flush_i  : load an invalid entry on advance
//   d_i      : entry from the previous stage
//   q_o      : current entry
// ---------------------------------------------------------------------------
module hazard_stage_track #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall_i,
   input  logic         flush_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] entry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= '0;
      end else if (!stall_i) begin
         // All-zero entry has RegWrite=0 and MemOp=0, i.e. a bubble.
         entry_q <= flush_i ? '0 : d_i;
      end
   end

   assign q_o = entry_q;
endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard/forwarding controller for a 5-stage RV32I pipeline. Shadows the
//   E/M/W destination registers, drives the execute operand forwarding selects,
//   resolves load-use and taken-branch hazards, and freezes the whole pipe
//   while data memory reports busy for a memory op in M.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_ctrl_if slave (decode/execute/memory status in,
//              Forward*/Stall*/Flush*/MemTimeout out)
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 5
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   localparam int EW = 3*REG_AW + 3;   // {Rs1,Rs2,Rd,RegWrite,IsLoad,MemOp}
   localparam int MW = REG_AW + 2;     // {Rd,RegWrite,MemOp}
   localparam int WW = REG_AW + 1;     // {Rd,RegWrite}; MemOp has no consumer past M
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WAIT - 1);

   // Shadow stages
   logic [EW-1:0]     e_d, e_q;
   logic [MW-1:0]     m_d, m_q;
   logic [WW-1:0]     w_d, w_q;
   logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic              reg_write_e, is_load_e, mem_op_e;
   logic              reg_write_m, mem_op_m, reg_write_w;
   logic              is_load_d;

   // Control
   hz_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_hit;
   logic              d_bubble_q;
   logic              stall_all, stall_fd, flush_d, flush_e;
   logic              load_use;

   assign is_load_d = (hz.ResultSrcD == RESULT_LOAD);
   assign e_d = {hz.Rs1D, hz.Rs2D, hz.RdD, hz.RegWriteD, is_load_d, hz.MemOpD};
   assign {rs1_e, rs2_e, rd_e, reg_write_e, is_load_e, mem_op_e} = e_q;
   assign m_d = {rd_e, reg_write_e, mem_op_e};
   assign {rd_m, reg_write_m, mem_op_m} = m_q;
   assign w_d = {rd_m, reg_write_m};
   assign {rd_w, reg_write_w} = w_q;

   // A D entry flushed last cycle is a bubble, so E must not capture it.
   hazard_stage_track #(.W(EW)) u_stage_e (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall_all),
      .flush_i (flush_e | d_bubble_q),
      .d_i     (e_d),
      .q_o     (e_q)
   );

   hazard_stage_track #(.W(MW)) u_stage_m (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall_all),
      .flush_i (1'b0),
      .d_i     (m_d),
      .q_o     (m_q)
   );

   hazard_stage_track #(.W(WW)) u_stage_w (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall_all),
      .flush_i (1'b0),
      .d_i     (w_d),
      .q_o     (w_q)
   );

   // Forwarding: M has the newer value so it wins over W; x0 never forwards.
   logic [REG_AW-1:0] rs_e    [2];
   fwd_sel_t          fwd_sel [2];

   assign rs_e[0] = rs1_e;
   assign rs_e[1] = rs2_e;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m, hit_w;
      assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e[gi]);
      assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e[gi]);
      assign fwd_sel[gi] = hit_m ? FWD_ALU : (hit_w ? FWD_WB : FWD_RF);
   end

   assign load_use = is_load_e && (rd_e != '0) &&
                     ((rd_e == hz.Rs1D) || (rd_e == hz.Rs2D));

   // FSM next state, wait counter and stall/flush decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
      stall_all   = 1'b0;
      stall_fd    = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;

      case (state_q)
         RUN: begin
            if (hz.MemBusyM && mem_op_m) begin
               // First busy cycle counts as wait index 0; counter starts at 1
               // for the next one.
               state_d     = MEM_WAIT;
               stall_all   = 1'b1;
               cnt_d       = CNT_W'(1);
               timeout_hit = (LAST_IDX == '0);
            end
         end
         MEM_WAIT: begin
            if (hz.MemBusyM) begin
               stall_all   = 1'b1;
               cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
               // >= keeps the flag asserting if the counter ever saturates.
               timeout_hit = (cnt_q >= LAST_IDX);
            end else begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      // When the pipe is not frozen (including the cycle busy drops) the
      // normal hazards apply; a taken branch discards the dependent instr.
      if (!stall_all) begin
         if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         d_bubble_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_q | timeout_hit;
         if (!(stall_all | stall_fd)) begin
            d_bubble_q <= flush_d;
         end
      end
   end

   assign hz.ForwardAE  = fwd_sel[0];
   assign hz.ForwardBE  = fwd_sel[1];
   assign hz.StallF     = stall_all | stall_fd;
   assign hz.StallD     = stall_all | stall_fd;
   assign hz.StallE     = stall_all;
   assign hz.StallM     = stall_all;
   assign hz.StallW     = stall_all;
   assign hz.FlushD     = flush_d;
   assign hz.FlushE     = flush_e;
   assign hz.MemTimeout = timeout_q | timeout_hit;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
   localparam int MAXW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_req = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_AW(5)) hz ();

   hazard_ctrl #(.REG_AW(5), .MAX_WAIT(MAXW), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One pipeline cycle: inputs change just after the rising edge, checks
   // happen on the falling edge.
   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic ld,
                        input logic mo, input logic pc, input logic busy);
      @(posedge clk);
      #1;
      rst           = rst_req;
      hz.Rs1D       = rs1;
      hz.Rs2D       = rs2;
      hz.RdD        = rd;
      hz.RegWriteD  = rw;
      hz.ResultSrcD = ld ? 2'b01 : 2'b00;
      hz.MemOpD     = mo;
      hz.PCSrcE     = pc;
      hz.MemBusyM   = busy;
      @(negedge clk);
   endtask

   task automatic nop(input logic busy);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, busy);
   endtask

   // ---------------- behavioural model ----------------
   // Each stage is simply "which instruction sits there"; the pipe either
   // advances as a whole or is frozen by memory.
   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld, mo;
   } e_ent_t;
   typedef struct packed {
      logic [4:0] rd;
      logic       rw, mo;
   } m_ent_t;

   e_ent_t me = '0;
   m_ent_t mm = '0;
   m_ent_t mw = '0;
   bit     d_bubble = 0;
   bit     frozen_prev = 0;
   bit     sticky = 0;
   int     streak = 0;

   bit     x_frz, x_lu, x_stfd, x_fld, x_fle, x_to;
   int     x_streak;

   function automatic int exp_fwd(input logic [4:0] rs);
      if (mm.rw && mm.rd != 5'd0 && mm.rd == rs) return 2;
      if (mw.rw && mw.rd != 5'd0 && mw.rd == rs) return 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      cyc++;
      // Frozen while memory is busy on the mem op in M, or still busy in a wait.
      x_frz    = hz.MemBusyM && (frozen_prev || mm.mo);
      x_streak = x_frz ? streak + 1 : 0;
      x_to     = sticky || (x_frz && x_streak >= MAXW);
      x_lu     = me.ld && me.rd != 5'd0 && (me.rd == hz.Rs1D || me.rd == hz.Rs2D);
      x_fld    = !x_frz && hz.PCSrcE;
      x_fle    = !x_frz && (hz.PCSrcE || x_lu);
      x_stfd   = x_frz || (!hz.PCSrcE && x_lu);

      $display("cyc %0d rst=%0b D=%0d,%0d->%0d ld=%0b pc=%0b busy=%0b | fa=%0d fb=%0d st=%b%b%b%b%b fl=%b%b to=%0b",
               cyc, rst, hz.Rs1D, hz.Rs2D, hz.RdD, hz.ResultSrcD == 2'b01, hz.PCSrcE, hz.MemBusyM,
               hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
               hz.StallW, hz.FlushD, hz.FlushE, hz.MemTimeout);

      chk("model_fwdA", int'(hz.ForwardAE), exp_fwd(me.rs1));
      chk("model_fwdB", int'(hz.ForwardBE), exp_fwd(me.rs2));
      chk("model_stall", int'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}),
          int'({x_stfd, x_stfd, x_frz, x_frz, x_frz}));
      chk("model_flush", int'({hz.FlushD, hz.FlushE}), int'({x_fld, x_fle}));
      chk("model_timeout", int'(hz.MemTimeout), int'(x_to));

      if (rst) begin
         me = '0; mm = '0; mw = '0;
         d_bubble = 0; frozen_prev = 0; sticky = 0; streak = 0;
      end else begin
         if (!x_frz) begin
            mw = mm;
            mm = {me.rd, me.rw, me.mo};
            if (x_fle || d_bubble) me = '0;
            else me = {hz.Rs1D, hz.Rs2D, hz.RdD, hz.RegWriteD,
                       hz.ResultSrcD == 2'b01, hz.MemOpD};
         end
         if (!x_stfd) d_bubble = x_fld;
         frozen_prev = x_frz;
         streak      = x_streak;
         sticky      = x_to;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0; hz.RegWriteD = 1'b0;
      hz.ResultSrcD = 2'b00; hz.MemOpD = 1'b0; hz.PCSrcE = 1'b0; hz.MemBusyM = 1'b0;
      @(negedge clk);
      chk("reset_outputs", int'({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
          hz.StallE, hz.StallM, hz.StallW, hz.FlushD, hz.FlushE, hz.MemTimeout}), 0);
      rst_req = 1'b0;

      // 1: add x5 ; add x6,x5,x1 -> M forward
      drive(5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 0);
      drive(5'd5, 5'd1, 5'd6, 1, 0, 0, 0, 0);
      nop(0);
      chk("t1_fwdA_alu", int'(hz.ForwardAE), 2);
      chk("t1_fwdB_rf", int'(hz.ForwardBE), 0);
      nop(0);
      //    add x5 ; nop ; add x6,x5,x1 -> W forward
      drive(5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 0);
      nop(0);
      drive(5'd5, 5'd1, 5'd6, 1, 0, 0, 0, 0);
      nop(0);
      chk("t1_fwdA_wb", int'(hz.ForwardAE), 1);
      nop(0);
      nop(0);

      // 2: lw x5 ; add x6,x5,x5 -> one-cycle load-use bubble
      drive(5'd1, 5'd0, 5'd5, 1, 1, 1, 0, 0);
      drive(5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 0);
      chk("t2_lu_stallF", int'(hz.StallF), 1);
      chk("t2_lu_stallD", int'(hz.StallD), 1);
      chk("t2_lu_flushE", int'(hz.FlushE), 1);
      chk("t2_lu_stallE", int'(hz.StallE), 0);
      drive(5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 0);
      chk("t2_after_stallF", int'(hz.StallF), 0);
      nop(0);
      chk("t2_fwdA_wb", int'(hz.ForwardAE), 1);
      chk("t2_fwdB_wb", int'(hz.ForwardBE), 1);
      //    lw x0 ; add x6,x0,x0 -> no stall
      drive(5'd1, 5'd0, 5'd0, 1, 1, 1, 0, 0);
      drive(5'd0, 5'd0, 5'd6, 1, 0, 0, 0, 0);
      chk("t2_x0_stallF", int'(hz.StallF), 0);
      chk("t2_x0_flushE", int'(hz.FlushE), 0);
      nop(0);
      nop(0);

      // 3: branch taken while load-use also present
      drive(5'd1, 5'd0, 5'd7, 1, 1, 1, 0, 0);
      drive(5'd7, 5'd0, 5'd8, 1, 0, 0, 1, 0);
      chk("t3_flushD", int'(hz.FlushD), 1);
      chk("t3_flushE", int'(hz.FlushE), 1);
      chk("t3_stallF", int'(hz.StallF), 0);
      nop(0);
      nop(0);

      // 4: add x4 ; lw x9 ; add x12,x4,x1 ; memory busy 3 cycles
      drive(5'd1, 5'd2, 5'd4, 1, 0, 0, 0, 0);
      drive(5'd3, 5'd0, 5'd9, 1, 1, 1, 0, 0);
      drive(5'd4, 5'd1, 5'd12, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         nop(1);
         chk($sformatf("t4_stall_all_%0d", i), int'({hz.StallF, hz.StallD, hz.StallE,
             hz.StallM, hz.StallW}), 31);
         chk($sformatf("t4_fwdA_%0d", i), int'(hz.ForwardAE), 1);
      end
      nop(0);
      chk("t4_run_stallF", int'(hz.StallF), 0);
      chk("t4_timeout", int'(hz.MemTimeout), 0);
      nop(0);
      nop(0);

      // 5: lw x13 reaches M, busy for 6 cycles with MAX_WAIT=4
      drive(5'd1, 5'd0, 5'd13, 1, 1, 1, 0, 0);
      nop(0);
      for (int i = 1; i <= 6; i++) begin
         nop(1);
         if (i == 3) chk("t5_timeout_busy3", int'(hz.MemTimeout), 0);
         if (i == 4) chk("t5_timeout_busy4", int'(hz.MemTimeout), 1);
      end
      nop(0);
      chk("t5_timeout_sticky", int'(hz.MemTimeout), 1);
      chk("t5_released", int'(hz.StallW), 0);
      rst_req = 1'b1;
      nop(0);
      rst_req = 1'b0;
      nop(0);
      chk("t5_timeout_cleared", int'(hz.MemTimeout), 0);

      // 6: add x14 ; sw x14 ; add x16,x14,x2 ; busy, then reset mid-wait
      drive(5'd1, 5'd2, 5'd14, 1, 0, 0, 0, 0);
      drive(5'd1, 5'd14, 5'd0, 0, 0, 1, 0, 0);
      drive(5'd14, 5'd2, 5'd16, 1, 0, 0, 0, 0);
      chk("t6_fwdB_alu", int'(hz.ForwardBE), 2);
      nop(1);
      chk("t6_wait_fwdA", int'(hz.ForwardAE), 1);
      nop(1);
      rst_req = 1'b1;
      nop(1);
      chk("t6_rst_cycle_stallE", int'(hz.StallE), 1);
      rst_req = 1'b0;
      nop(1);
      chk("t6_after_rst_outputs", int'({hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
          hz.StallE, hz.StallM, hz.StallW, hz.FlushD, hz.FlushE, hz.MemTimeout}), 0);
      nop(0);
      nop(0);

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
